// File: rtl/piso_pkg.sv
// piso_pkg: shared types and helpers for the piso_tx parallel-in/serial-out transmitter.
//   piso_state_e : FSM state encoding (ST_PARITY is only reached when PISO_PARITY_EN is defined)
//   cnt_width()  : chunk-counter width for a given chunk count (never below 1 bit)
package piso_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_PARITY
    } piso_state_e;

    function automatic int unsigned cnt_width(input int unsigned chunks);
        return (chunks > 1) ? $clog2(chunks) : 1;
    endfunction

endpackage

// File: rtl/piso_tx_if.sv
// piso_tx_if: handshake bundle between a parallel word source, piso_tx and a serial sink.
//   i_valid / o_ready / i_data : parallel word side (source -> piso_tx)
//   o_valid / i_ready / o_data : serial chunk side (piso_tx -> sink), o_data LSB-first
//   o_last                     : current chunk closes its word
//   o_idle                     : transmitter holds no pending data
// Modports: slave = piso_tx view, master = environment view.
interface piso_tx_if #(
    parameter int unsigned SIZE_DATA_IN  = 8,
    parameter int unsigned SIZE_DATA_OUT = 1
);

    logic                     i_valid;
    logic                     o_ready;
    logic [SIZE_DATA_IN-1:0]  i_data;
    logic                     o_valid;
    logic                     i_ready;
    logic [SIZE_DATA_OUT-1:0] o_data;
    logic                     o_last;
    logic                     o_idle;

    modport slave (
        input  i_valid, i_data, i_ready,
        output o_ready, o_valid, o_data, o_last, o_idle
    );

    modport master (
        output i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_data, o_last, o_idle
    );

endinterface

// File: rtl/piso_hold_buf.sv
// piso_hold_buf: one-entry word buffer that lets piso_tx accept the next word while the
// current one is still being shifted out.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_load       : capture i_data (caller only loads when empty)
//   i_pop        : release the held word (caller only pops when full)
//   o_full       : a word is held
//   o_data       : held word
module piso_hold_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);

    logic             full_q;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (i_load) begin
            full_q <= 1'b1;
            data_q <= i_data;
        end else if (i_pop) begin
            full_q <= 1'b0;
        end
    end

    assign o_full = full_q;
    assign o_data = data_q;

endmodule

// File: rtl/piso_tx.sv
// piso_tx: parallel-in/serial-out transmitter. Accepts SIZE_DATA_IN-bit words on a valid/ready
// handshake and emits them LSB-first as SIZE_DATA_OUT-bit chunks on a valid/ready stream.
// SIZE_DATA_IN must be an integer multiple of SIZE_DATA_OUT.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : piso_tx_if.slave (word input, chunk output, o_last, o_idle)
// Build option: define PISO_PARITY_EN to append one even-parity chunk (bit0 = XOR of the word,
// upper bits 0) after the data chunks of every word; o_last then marks that parity chunk.
module piso_tx
    import piso_pkg::*;
#(
    parameter int unsigned SIZE_DATA_IN  = 8,
    parameter int unsigned SIZE_DATA_OUT = 1
) (
    input  logic     i_clk,
    input  logic     i_rst,
    piso_tx_if.slave bus
);

    localparam int unsigned      CHUNKS   = SIZE_DATA_IN / SIZE_DATA_OUT;
    localparam int unsigned      CNT_W    = cnt_width(CHUNKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHUNKS - 1);
`ifdef PISO_PARITY_EN
    localparam logic             LAST_ON_LOAD = 1'b0;
`else
    // A single-chunk word is its own last chunk.
    localparam logic             LAST_ON_LOAD = (CHUNKS == 1);
`endif

    piso_state_e             state_q;
    logic [SIZE_DATA_IN-1:0] shift_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_nxt;
    logic                    valid_q;
    logic                    last_q;
`ifdef PISO_PARITY_EN
    logic                    parity_q;
`endif

    logic                    buf_full;
    logic [SIZE_DATA_IN-1:0] buf_data;
    logic                    ready;
    logic                    accept;
    logic                    xfer;
    logic                    word_done;
    logic                    buf_load;
    logic                    buf_pop;
    logic                    load_next;
    logic [SIZE_DATA_IN-1:0] next_word;

    always_comb begin
        ready     = !i_rst && !buf_full;
        accept    = bus.i_valid && ready;
        xfer      = valid_q && bus.i_ready;
        word_done = xfer && last_q;
        // The buffer feeds the shifter first; o_ready is low while it is full, so a pop
        // never coincides with an accept.
        buf_pop   = word_done && buf_full;
        // An accept bypasses the buffer when the shifter is free now or frees up this edge.
        buf_load  = accept && (state_q != ST_IDLE) && !word_done;
        load_next = buf_pop || (accept && ((state_q == ST_IDLE) || word_done));
        next_word = buf_full ? buf_data : bus.i_data;
        cnt_nxt   = cnt_q + CNT_W'(1);
    end

    piso_hold_buf #(
        .WIDTH (SIZE_DATA_IN)
    ) u_hold_buf (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (buf_load),
        .i_data (bus.i_data),
        .i_pop  (buf_pop),
        .o_full (buf_full),
        .o_data (buf_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else if (load_next) begin
            state_q  <= ST_SHIFT;
            shift_q  <= next_word;
            cnt_q    <= '0;
            valid_q  <= 1'b1;
            last_q   <= LAST_ON_LOAD;
`ifdef PISO_PARITY_EN
            parity_q <= ^next_word;
`endif
        end else if (word_done) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else if (xfer) begin
`ifdef PISO_PARITY_EN
            if (cnt_q == CNT_LAST) begin
                // Final data chunk gone: present the parity chunk next.
                state_q <= ST_PARITY;
                shift_q <= SIZE_DATA_IN'(parity_q);
                last_q  <= 1'b1;
            end else begin
                shift_q <= shift_q >> SIZE_DATA_OUT;
                cnt_q   <= cnt_nxt;
                last_q  <= 1'b0;
            end
`else
            shift_q <= shift_q >> SIZE_DATA_OUT;
            cnt_q   <= cnt_nxt;
            last_q  <= (cnt_nxt == CNT_LAST);
`endif
        end
    end

    assign bus.o_ready = ready;
    assign bus.o_valid = valid_q;
    assign bus.o_data  = shift_q[SIZE_DATA_OUT-1:0];
    assign bus.o_last  = last_q;
    assign bus.o_idle  = (state_q == ST_IDLE);

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: self-checking bench for piso_tx. A queue of expected chunks (filled from every
// accepted word, drained on every chunk transfer) is compared against the DUT each cycle,
// directed scenarios pin the model with literal values, then randomized traffic runs.
module tb_piso_tx;

`ifdef PISO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    piso_tx_if #(.SIZE_DATA_IN(8), .SIZE_DATA_OUT(1)) bus ();
    piso_tx_if #(.SIZE_DATA_IN(8), .SIZE_DATA_OUT(2)) bus2 ();

    piso_tx #(.SIZE_DATA_IN(8), .SIZE_DATA_OUT(1)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    piso_tx #(.SIZE_DATA_IN(8), .SIZE_DATA_OUT(2)) dut2 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus2.slave)
    );

    typedef struct {
        logic [1:0] d;
        logic       l;
    } chunk_t;

    int checks = 0;
    int errors = 0;

    chunk_t     q[$];
    chunk_t     pc;
    int         words = 0;
    int         cyc = 0;
    int         acc_cyc = 0;
    int         ready_low = 0;
    logic [1:0] log_d[$];
    logic       log_l[$];
    int         log_c[$];
    logic [1:0] log2_d[$];
    logic       log2_l[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    function automatic void push_word(input logic [7:0] w);
        chunk_t c;
        for (int k = 0; k < 8; k++) begin
            c.d = {1'b0, w[k]};
            c.l = (k == 7) && (PAR == 0);
            q.push_back(c);
        end
`ifdef PISO_PARITY_EN
        c.d = {1'b0, ^w};
        c.l = 1'b1;
        q.push_back(c);
`endif
    endfunction

    // Model and per-cycle compare for the 1-bit instance; sampled mid-cycle, so the handshakes
    // seen here are exactly those taken at the next rising edge.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            words = 0;
            chk("ready_in_reset", bus.o_ready, 0);
        end else begin
            chk("o_valid", bus.o_valid, q.size() != 0);
            chk("o_ready", bus.o_ready, words < 2);
            chk("o_idle", bus.o_idle, words == 0);
            if (q.size() != 0) begin
                chk("o_data", bus.o_data, q[0].d);
                chk("o_last", bus.o_last, q[0].l);
            end
            if (!bus.o_ready) ready_low++;
            if (bus.o_valid && bus.i_ready && q.size() != 0) begin
                pc = q.pop_front();
                log_d.push_back({1'b0, bus.o_data});
                log_l.push_back(bus.o_last);
                log_c.push_back(cyc);
                if (pc.l) words--;
            end
            if (bus.i_valid && bus.o_ready) begin
                push_word(bus.i_data);
                words++;
                acc_cyc = cyc;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus2.o_valid && bus2.i_ready) begin
            log2_d.push_back(bus2.o_data);
            log2_l.push_back(bus2.o_last);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        log_d.delete();
        log_l.delete();
        log_c.delete();
    endtask

    task automatic send(input logic [7:0] w);
        int n = 0;
        bus.i_valid = 1'b1;
        bus.i_data  = w;
        @(negedge clk);
        while (!bus.o_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) timeout("send");
        tick();
        bus.i_valid = 1'b0;
    endtask

    task automatic send2(input logic [7:0] w);
        int n = 0;
        bus2.i_valid = 1'b1;
        bus2.i_data  = w;
        @(negedge clk);
        while (!bus2.o_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) timeout("send2");
        tick();
        bus2.i_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(bus.o_idle && q.size() == 0) && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (n >= 300) timeout("wait_idle");
        tick();
    endtask

    task automatic wait_idle2();
        int n = 0;
        @(negedge clk);
        while (!bus2.o_idle && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (n >= 300) timeout("wait_idle2");
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [1:0] exp_aa [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    logic [1:0] exp_0f [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    logic [1:0] exp_b4 [4] = '{0, 1, 3, 2};

    initial begin
        int a;
        int n;
        logic [7:0] w2 [6];

        bus.i_valid  = 1'b0;
        bus.i_data   = '0;
        bus.i_ready  = 1'b1;
        bus2.i_valid = 1'b0;
        bus2.i_data  = '0;
        bus2.i_ready = 1'b1;

        // 1: reset values, then 0xAA with the sink always ready
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_o_valid", bus.o_valid, 0);
        chk("rst_o_data", bus.o_data, 0);
        chk("rst_o_last", bus.o_last, 0);
        chk("rst_o_idle", bus.o_idle, 1);
        chk("rst_o_ready", bus.o_ready, 1);
        tick();
        clear_logs();
        send(8'hAA);
        a = acc_cyc;
        wait_idle();
        chk("t1_len", log_d.size(), 8 + PAR);
        chk("t1_latency", log_c[0] - a, 1);
        for (int i = 0; i < 8; i++) begin
            chk("t1_bit", log_d[i], exp_aa[i]);
            chk("t1_last", log_l[i], (i == 7) && (PAR == 0));
        end

        // 2: three words back to back -> one unbroken run of chunks
        clear_logs();
        ready_low = 0;
        send(8'hAA);
        send(8'hCC);
        send(8'hF0);
        wait_idle();
        chk("t2_len", log_d.size(), 3 * (8 + PAR));
        for (int i = 1; i < log_c.size(); i++) chk("t2_no_bubble", log_c[i] - log_c[0], i);
        chk("t2_ready_dropped", ready_low > 0, 1);

        // 3: 0x55, sink stalls three cycles while chunk 2 is presented
        clear_logs();
        send(8'h55);
        a = acc_cyc;
        tick();
        tick();
        bus.i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", bus.o_valid, 1);
            chk("t3_hold_data", bus.o_data, 1);
            tick();
        end
        bus.i_ready = 1'b1;
        wait_idle();
        chk("t3_len", log_d.size(), 8 + PAR);
        chk("t3_duration", log_c[log_c.size() - 1] - a, 11 + PAR);
        chk("t3_last", log_l[log_l.size() - 1], 1);

        // 4: reset after three bits of 0xF0, then a clean 0x0F
        clear_logs();
        send(8'hF0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t4_o_valid", bus.o_valid, 0);
        chk("t4_o_idle", bus.o_idle, 1);
        chk("t4_bits_before_rst", log_d.size(), 3);
        tick();
        clear_logs();
        send(8'h0F);
        wait_idle();
        chk("t4_len", log_d.size(), 8 + PAR);
        for (int i = 0; i < 8; i++) chk("t4_bit", log_d[i], exp_0f[i]);

`ifdef PISO_PARITY_EN
        // 5: parity chunk values
        clear_logs();
        send(8'h07);
        wait_idle();
        chk("t5_len", log_d.size(), 9);
        chk("t5_par07", log_d[8], 1);
        chk("t5_last07", log_l[8], 1);
        chk("t5_not_last", log_l[7], 0);
        clear_logs();
        send(8'h03);
        wait_idle();
        chk("t5_par03", log_d[8], 0);
        chk("t5_last03", log_l[8], 1);
`endif

        // Randomized traffic with occasional resets, checked cycle by cycle by the model
        for (int i = 0; i < 3000; i++) begin
            bus.i_valid = ($urandom_range(0, 99) < 60);
            bus.i_data  = 8'($urandom);
            bus.i_ready = ($urandom_range(0, 99) < 75);
            rst         = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst         = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        wait_idle();

        // 6: two-bit chunks, 0xB4
        log2_d.delete();
        log2_l.delete();
        send2(8'hB4);
        wait_idle2();
        chk("t6_len", log2_d.size(), 4 + PAR);
        for (int i = 0; i < 4; i++) begin
            chk("t6_chunk", log2_d[i], exp_b4[i]);
            chk("t6_last", log2_l[i], (i == 3) && (PAR == 0));
        end

        // Random words on the two-bit instance, expected chunks by arithmetic
        log2_d.delete();
        log2_l.delete();
        for (int i = 0; i < 6; i++) begin
            w2[i] = 8'($urandom);
            send2(w2[i]);
        end
        wait_idle2();
        chk("t6r_len", log2_d.size(), 6 * (4 + PAR));
        n = 0;
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (n < log2_d.size()) begin
                    chk("t6r_chunk", log2_d[n], (w2[i] >> (2 * k)) & 8'h3);
                    chk("t6r_last", log2_l[n], (k == 3) && (PAR == 0));
                end
                n++;
            end
`ifdef PISO_PARITY_EN
            if (n < log2_d.size()) begin
                chk("t6r_parity", log2_d[n], ^w2[i]);
                chk("t6r_parity_last", log2_l[n], 1);
            end
            n++;
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
